// File: rtl/logic_gate_pkg.sv
// Shared definitions for the logic gate unit: operation codes and FSM states.
package logic_gate_pkg;

   localparam int OP_W = 3;

   // Operation codes as seen on in_op / sweep_op.
   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_NAND = 3'd2,
      OP_NOR  = 3'd3,
      OP_XOR  = 3'd4,
      OP_XNOR = 3'd5,
      OP_NOT  = 3'd6,
      OP_BUF  = 3'd7
   } op_e;

   // Truth-table capture sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/logic_gate_unit_if.sv
// Streaming handshake bundle: operand/op input channel and result output channel.
interface logic_gate_unit_if #(
   parameter int WIDTH  = 8,
   parameter int NUM_IN = 2
) ();

   logic                    in_valid;
   logic                    in_ready;
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [2:0]              in_op;
   logic                    out_valid;
   logic                    out_ready;
   logic [WIDTH-1:0]        out_data;

   // Producer / consumer side (drives operands, accepts results).
   modport master (
      output in_valid, in_data, in_op, out_ready,
      input  in_ready, out_valid, out_data
   );

   // Logic gate unit side.
   modport slave (
      input  in_valid, in_data, in_op, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/logic_gate_eval.sv
// Purely combinational evaluator: applies one op bitwise across NUM_IN
// operands of WIDTH lanes each. Operand k sits at [k*WIDTH +: WIDTH].
module logic_gate_eval
   import logic_gate_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int NUM_IN = 2
) (
   input  logic [NUM_IN*WIDTH-1:0] operands,
   input  op_e                     op,
   output logic [WIDTH-1:0]        result
);

   logic [WIDTH-1:0] and_s;
   logic [WIDTH-1:0] or_s;
   logic [WIDTH-1:0] xor_s;
   logic [WIDTH-1:0] op0_s;

   assign op0_s = operands[WIDTH-1:0];

   // Reduce all operands lane-wise into AND / OR / XOR terms.
   always_comb begin
      and_s = {WIDTH{1'b1}};
      or_s  = {WIDTH{1'b0}};
      xor_s = {WIDTH{1'b0}};
      for (int k = 0; k < NUM_IN; k++) begin
         and_s = and_s & operands[k*WIDTH +: WIDTH];
         or_s  = or_s  | operands[k*WIDTH +: WIDTH];
         xor_s = xor_s ^ operands[k*WIDTH +: WIDTH];
      end
   end

   // Select the requested function; NOT/BUF look at operand 0 only.
   always_comb begin
      result = {WIDTH{1'b0}};
      case (op)
         OP_AND:  result = and_s;
         OP_OR:   result = or_s;
         OP_NAND: result = ~and_s;
         OP_NOR:  result = ~or_s;
         OP_XOR:  result = xor_s;
         OP_XNOR: result = ~xor_s;
         OP_NOT:  result = ~op0_s;
         OP_BUF:  result = op0_s;
         default: result = {WIDTH{1'b0}};
      endcase
   end

endmodule

// File: rtl/logic_gate_unit.sv
// Logic gate unit: a one-deep registered streaming evaluator plus a
// truth-table capture sequencer that walks every single-bit input pattern.
module logic_gate_unit
   import logic_gate_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int NUM_IN = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   logic_gate_unit_if.slave     bus,
   input  logic                 sweep_start,
   input  logic [2:0]           sweep_op,
   output logic                 sweep_busy,
   output logic                 sweep_done,
   output logic [2**NUM_IN-1:0] truth_table
);

   localparam int                TT_W     = 2**NUM_IN;
   localparam logic [NUM_IN-1:0] LAST_IDX = {NUM_IN{1'b1}};
   localparam logic [NUM_IN-1:0] IDX_ONE  = {{(NUM_IN-1){1'b0}}, 1'b1};

   state_e              state_r;
   state_e              state_next_s;
   op_e                 sweep_op_r;
   op_e                 stream_op_s;
   logic [NUM_IN-1:0]   index_r;
   logic [TT_W-1:0]     tt_r;
   logic                busy_r;
   logic                done_r;
   logic                run_en_r;
   logic                out_valid_r;
   logic [WIDTH-1:0]    out_data_r;
   logic                idle_s;
   logic                start_s;
   logic                in_ready_s;
   logic                accept_s;
   logic                consume_s;
   logic [WIDTH-1:0]    stream_result_s;
   logic [0:0]          sweep_bit_s;

   // run_en_r holds the unit quiet until the first clock edge after reset
   // releases, so in_ready is low for the whole reset period.
   assign idle_s      = run_en_r & (state_r == ST_IDLE);
   assign start_s     = idle_s & sweep_start;
   assign in_ready_s  = idle_s & ~sweep_start & (~out_valid_r | bus.out_ready);
   assign accept_s    = bus.in_valid & in_ready_s;
   assign consume_s   = out_valid_r & bus.out_ready;
   assign stream_op_s = op_e'(bus.in_op);

   logic_gate_eval #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN)
   ) u_stream_eval (
      .operands (bus.in_data),
      .op       (stream_op_s),
      .result   (stream_result_s)
   );

   // The sweep index bits are directly the single-bit operands.
   logic_gate_eval #(
      .WIDTH  (1),
      .NUM_IN (NUM_IN)
   ) u_sweep_eval (
      .operands (index_r),
      .op       (sweep_op_r),
      .result   (sweep_bit_s)
   );

   // Release the unit one cycle after reset deasserts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_en_r <= 1'b0;
      end else begin
         run_en_r <= 1'b1;
      end
   end

   // Output register: load on accept, drop valid on a consume without accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_data_r  <= {WIDTH{1'b0}};
      end else if (accept_s) begin
         out_valid_r <= 1'b1;
         out_data_r  <= stream_result_s;
      end else if (consume_s) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   // Sequencer next state: sweep_start only acts from IDLE.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_s) begin
               state_next_s = ST_SWEEP;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_SWEEP: begin
            if (index_r == LAST_IDX) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_SWEEP;
            end
         end
         ST_DONE: state_next_s = ST_IDLE;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Sequencer state plus busy/done flags registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         busy_r  <= (state_next_s != ST_IDLE);
         done_r  <= (state_next_s == ST_DONE);
      end
   end

   // Sweep datapath: latch op and clear on start, write one table bit per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sweep_op_r <= OP_AND;
         index_r    <= {NUM_IN{1'b0}};
         tt_r       <= {TT_W{1'b0}};
      end else if (start_s) begin
         sweep_op_r <= op_e'(sweep_op);
         index_r    <= {NUM_IN{1'b0}};
         tt_r       <= {TT_W{1'b0}};
      end else if (state_r == ST_SWEEP) begin
         tt_r[index_r] <= sweep_bit_s[0];
         index_r       <= index_r + IDX_ONE;
      end else begin
         tt_r <= tt_r;
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign sweep_busy    = busy_r;
   assign sweep_done    = done_r;
   assign truth_table   = tt_r;

endmodule
